// File: rtl/segre_mmu_ic_refill.sv
// segre_mmu_ic_refill: services IF-stage icache misses. It aligns the miss
// address to a line, reads the line from main memory as BEATS beats, and
// returns it with a one-cycle strobe.
// Optional feature macro: SEGRE_IC_REFILL_LBUF_EN (one-entry last-line buffer).
// When the macro is set, a miss to the most recently delivered line is served
// without a memory read.
module segre_mmu_ic_refill #(
  parameter int ADDR_W = 32,
  parameter int LANE_W = 128,
  parameter int BEAT_W = 32
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              ic_miss_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_mmu_data_o,
  output logic [LANE_W-1:0] ic_mmu_wr_data_o,
  output logic [ADDR_W-1:0] ic_mmu_addr_o,
  output logic              busy_o,
  output logic              mm_rd_req_o,
  output logic [ADDR_W-1:0] mm_rd_addr_o,
  input  logic              mm_rd_gnt_i,
  input  logic              mm_rd_valid_i,
  input  logic [BEAT_W-1:0] mm_rd_data_i
);
  localparam int BEATS = LANE_W / BEAT_W;
  localparam int OFF_W = $clog2(LANE_W / 8);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RECV, RESP} state_t;

  state_t                       r_state, w_state_nxt;
  logic [CNT_W-1:0]             r_beat_cnt;
  logic [ADDR_W-1:0]            r_line_addr;
  logic [BEATS-1:0][BEAT_W-1:0] r_buf, w_buf_nxt;
  logic [LANE_W-1:0]            r_out_data;
  logic [ADDR_W-1:0]            r_out_addr;
  logic [ADDR_W-1:0]            w_miss_line;
  logic                         w_last_beat;
  logic                         w_lbuf_hit;
  logic                         w_unused;

  assign w_miss_line = {ic_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_unused    = &{1'b0, ic_addr_i[OFF_W-1:0]};
  assign w_last_beat = (r_state == RECV) && mm_rd_valid_i &&
                       (r_beat_cnt == CNT_W'(BEATS - 1));

`ifdef SEGRE_IC_REFILL_LBUF_EN
  // The output registers already hold the last delivered line and its
  // address, so the last-line buffer only needs a valid flag on top.
  logic r_lbuf_valid;

  // Set once a line has been delivered; cleared only by reset.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i)           r_lbuf_valid <= 1'b0;
    else if (w_last_beat) r_lbuf_valid <= 1'b1;
  end

  assign w_lbuf_hit = r_lbuf_valid && (w_miss_line == r_out_addr);
`else
  assign w_lbuf_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt   = r_state;
    busy_o        = 1'b1;
    mm_rd_req_o   = 1'b0;
    mm_rd_addr_o  = '0;
    ic_mmu_data_o = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy_o = 1'b0;
        if (ic_miss_i) w_state_nxt = w_lbuf_hit ? RESP : REQ;
      end
      REQ: begin
        mm_rd_req_o  = 1'b1;
        mm_rd_addr_o = r_line_addr;
        if (mm_rd_gnt_i) w_state_nxt = RECV;
      end
      RECV: begin
        if (w_last_beat) w_state_nxt = RESP;
      end
      RESP: begin
        ic_mmu_data_o = 1'b1;
        w_state_nxt   = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Assembly buffer: cleared on a new miss, beat 0 lands in the LSBs.
  always_comb begin
    w_buf_nxt = r_buf;
    if (r_state == IDLE && ic_miss_i)
      w_buf_nxt = '0;
    else if (r_state == RECV && mm_rd_valid_i)
      w_buf_nxt[r_beat_cnt] = mm_rd_data_i;
  end

  // Datapath registers: buffer, beat counter, line address, returned line.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_buf       <= '0;
      r_beat_cnt  <= '0;
      r_line_addr <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
    end else begin
      r_buf <= w_buf_nxt;
      if (r_state == IDLE && ic_miss_i)
        r_line_addr <= w_miss_line;
      if (r_state == REQ && mm_rd_gnt_i)
        r_beat_cnt <= '0;
      else if (r_state == RECV && mm_rd_valid_i)
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      // Loading on the final beat makes the line visible in the RESP cycle
      // and keeps it stable afterwards.
      if (w_last_beat) begin
        r_out_data <= w_buf_nxt;
        r_out_addr <= r_line_addr;
      end
    end
  end

  assign ic_mmu_wr_data_o = r_out_data;
  assign ic_mmu_addr_o    = r_out_addr;

endmodule

// File: tb/tb_segre_mmu_ic_refill.sv
// Directed bench for segre_mmu_ic_refill (LANE_W=128, BEAT_W=32, 4 beats).
module tb_segre_mmu_ic_refill;
  logic         clk = 1'b0;
  logic         rsn = 1'b0;
  logic         miss = 1'b0;
  logic [31:0]  addr = '0;
  logic         gnt = 1'b0;
  logic         valid = 1'b0;
  logic [31:0]  rdata = '0;
  logic         strobe;
  logic [127:0] wr_data;
  logic [31:0]  ic_addr;
  logic         busy;
  logic         req;
  logic [31:0]  rd_addr;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  segre_mmu_ic_refill #(.ADDR_W(32), .LANE_W(128), .BEAT_W(32)) dut (
    .clk_i(clk), .rsn_i(rsn), .ic_miss_i(miss), .ic_addr_i(addr),
    .ic_mmu_data_o(strobe), .ic_mmu_wr_data_o(wr_data), .ic_mmu_addr_o(ic_addr),
    .busy_o(busy), .mm_rd_req_o(req), .mm_rd_addr_o(rd_addr),
    .mm_rd_gnt_i(gnt), .mm_rd_valid_i(valid), .mm_rd_data_i(rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_strobe"}, strobe, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_ic_addr"}, ic_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req"}, req, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
  endtask

  // One complete refill from IDLE. gdly: idle cycles before grant; gap: beat
  // index preceded by one valid=0 cycle (-1 = none); spur: inject stray
  // valids and toggle the miss line while beats arrive.
  task automatic refill(input logic [31:0] a, input int gdly, input int gap,
                        input bit spur, input logic [31:0] d0,
                        input logic [127:0] exp_line, input int exp_cyc);
    logic [31:0] la;
    int c0;
    int k;
    la = a & 32'hFFFF_FFF0;
    if (spur) begin
      valid = 1'b1; rdata = 32'hDEAD_BEEF;
      step();
      chk("spur_idle_busy", busy, 0);
      valid = 1'b0;
    end
    miss = 1'b1; addr = a; c0 = cyc;
    step();
    for (int g = 0; g < gdly; g++) begin
      chk("req_wait", req, 1);
      chk("req_addr_wait", rd_addr, la);
      step();
    end
    gnt = 1'b1;
    if (spur) begin valid = 1'b1; rdata = 32'hBAD0_0BAD; end
    chk("req_gnt", req, 1);
    chk("req_addr_gnt", rd_addr, la);
    step();
    gnt = 1'b0; valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b == gap) begin valid = 1'b0; step(); end
      if (spur) miss = b[0];
      valid = 1'b1; rdata = d0 + 32'(b);
      step();
    end
    valid = 1'b0; miss = 1'b1;
    k = 0;
    while (!strobe && k < 20) begin step(); k++; end
    chk("strobe_seen", strobe, 1);
    chk("strobe_cycle", cyc - c0, exp_cyc);
    chk("line", wr_data, exp_line);
    chk("line_addr", ic_addr, la);
    chk("busy_resp", busy, 1);
    miss = 1'b0;
    step();
    chk("strobe_one_cycle", strobe, 0);
    chk("line_hold", wr_data, exp_line);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    // Reset state.
    step(); step();
    chk_all_zero("rst");
    rsn = 1'b1;
    step();
    chk_all_zero("rst_rel");

    // Basic refill.
    refill(32'h1008, 0, -1, 1'b0, 32'hA0,
           128'h000000A3_000000A2_000000A1_000000A0, 6);

    // Grant stall of 3 cycles plus one gap between beats 1 and 2.
    refill(32'h5010, 3, 2, 1'b0, 32'hA0,
           128'h000000A3_000000A2_000000A1_000000A0, 10);

    // Spurious valids and miss toggling.
    refill(32'h6000, 0, -1, 1'b1, 32'h60,
           128'h00000063_00000062_00000061_00000060, 6);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("spur_no_extra_req", req, 0);
      chk("spur_no_extra_strobe", strobe, 0);
    end

    // Reset in the middle of RECV, while beat 2 is presented.
    miss = 1'b1; addr = 32'h100;
    step();
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    valid = 1'b1; rdata = 32'hB0; step();
    rdata = 32'hB1; step();
    rdata = 32'hB2;
    rsn = 1'b0;
    #1;
    chk_all_zero("midrst");
    miss = 1'b0; valid = 1'b0;
    step(); step();
    rsn = 1'b1;
    step();
    chk("midrst_no_strobe", strobe, 0);
    chk("midrst_idle", busy, 0);
    refill(32'h100, 0, -1, 1'b0, 32'hC0,
           128'h000000C3_000000C2_000000C1_000000C0, 6);

    // Back-to-back misses, the second raised the cycle after the strobe.
    refill(32'h2000, 0, -1, 1'b0, 32'h20,
           128'h00000023_00000022_00000021_00000020, 6);
    refill(32'h3004, 0, -1, 1'b0, 32'h30,
           128'h00000033_00000032_00000031_00000030, 6);

    // Last-line buffer.
    refill(32'h4000, 0, -1, 1'b0, 32'hD0,
           128'h000000D3_000000D2_000000D1_000000D0, 6);
`ifdef SEGRE_IC_REFILL_LBUF_EN
    begin
      int c0;
      miss = 1'b1; addr = 32'h400C; c0 = cyc;
      step();
      chk("lbuf_strobe", strobe, 1);
      chk("lbuf_cycle", cyc - c0, 1);
      chk("lbuf_req", req, 0);
      chk("lbuf_line", wr_data, 128'h000000D3_000000D2_000000D1_000000D0);
      chk("lbuf_addr", ic_addr, 32'h4000);
      miss = 1'b0;
      step();
      chk("lbuf_strobe_off", strobe, 0);
      chk("lbuf_req_off", req, 0);
    end
`else
    refill(32'h400C, 0, -1, 1'b0, 32'hE0,
           128'h000000E3_000000E2_000000E1_000000E0, 6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
